// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage
// Description : Instruction FIFO + operand register file feeding a
//               combinational ALU; captures and hands off results downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
  parameter int DEPTH = 4,
  parameter int NREG  = 4,
  parameter int RW    = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [RW-1:0] in_rd,
  input  logic [RW-1:0] in_rs1,
  input  logic [RW-1:0] in_rs2,
  input  logic          ld_valid,
  input  logic [RW-1:0] ld_rd,
  input  logic [7:0]    ld_data,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [3:0]    alu_op,
  input  logic [7:0]    alu_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [7:0]    res_data,
  output logic [RW-1:0] res_rd,
  output logic          busy
);

  localparam int                 c_ptr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                 c_cnt_w    = $clog2(DEPTH + 1);
  localparam logic [3:0]         c_idle_op  = 4'b1111;
  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

  // Instruction FIFO storage, one array per field
  logic [3:0]    r_q_op  [DEPTH];
  logic [RW-1:0] r_q_rd  [DEPTH];
  logic [RW-1:0] r_q_rs1 [DEPTH];
  logic [RW-1:0] r_q_rs2 [DEPTH];

  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_cnt_w-1:0] r_count;

  logic [7:0]    r_regs [NREG];
  logic          r_res_valid;
  logic [7:0]    r_res_data;
  logic [RW-1:0] r_res_rd;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_issue;
  logic [3:0]    w_head_op;
  logic [RW-1:0] w_head_rd;
  logic [RW-1:0] w_head_rs1;
  logic [RW-1:0] w_head_rs2;

  assign w_full     = (r_count == c_full_cnt);
  assign w_empty    = (r_count == '0);
  // No pass-through when full: a same-cycle pop does not open a slot.
  assign w_push     = in_valid && !w_full;
  // Loads own the register write port, so they stall issue outright.
  assign w_issue    = !w_empty && !ld_valid && (!r_res_valid || res_ready);

  assign w_head_op  = r_q_op[r_rptr];
  assign w_head_rd  = r_q_rd[r_rptr];
  assign w_head_rs1 = r_q_rs1[r_rptr];
  assign w_head_rs2 = r_q_rs2[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_op[r_wptr]  <= in_op;
      r_q_rd[r_wptr]  <= in_rd;
      r_q_rs1[r_wptr] <= in_rs1;
      r_q_rs2[r_wptr] <= in_rs2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_ptr_one;
      end
      if (w_issue) begin
        r_rptr <= r_rptr + c_ptr_one;
      end
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (ld_valid) begin
      r_regs[ld_rd] <= ld_data;
    end else if (w_issue) begin
      r_regs[w_head_rd] <= alu_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_rd    <= '0;
    end else if (w_issue) begin
      r_res_valid <= 1'b1;
      r_res_data  <= alu_out;
      r_res_rd    <= w_head_rd;
    end else if (r_res_valid && res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  // Idle cycles present zero operands and the idle opcode so the ALU outputs 0.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = c_idle_op;
    if (w_issue) begin
      alu_a  = r_regs[w_head_rs1];
      alu_b  = r_regs[w_head_rs2];
      alu_op = w_head_op;
    end
  end

  assign in_ready  = !w_full;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_rd    = r_res_rd;
  assign busy      = !w_empty || r_res_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// Bench for alu_issue_stage: queue-based reference model checked every
// negedge, plus directed scenarios with hand-computed expectations.
module tb_alu_issue_stage;

  localparam int DEPTH = 4;
  localparam int NREG  = 4;
  localparam int RW    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_op = '0;
  logic [RW-1:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic          ld_valid = 1'b0;
  logic [RW-1:0] ld_rd = '0;
  logic [7:0]    ld_data = '0;
  logic [7:0]    alu_a, alu_b, alu_out;
  logic [3:0]    alu_op;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [7:0]    res_data;
  logic [RW-1:0] res_rd;
  logic          busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Stand-in for the downstream ALU; ops 1001-1111 return 0.
  function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return {a[6:0], 1'b0};
      4'd3:    return {1'b0, a[7:1]};
      4'd4:    return a & b;
      4'd5:    return a ^ b;
      4'd6:    return ~a;
      4'd7:    return a | b;
      4'd8:    return b;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_out = alu_ref(alu_op, alu_a, alu_b);

  alu_issue_stage #(.DEPTH(DEPTH), .NREG(NREG), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_rd(res_rd), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0]    op;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
  } ins_t;

  ins_t          mq[$];
  ins_t          e_ins;
  logic [7:0]    mreg [NREG];
  logic          mres_valid = 1'b0;
  logic [7:0]    mres_data = '0;
  logic [RW-1:0] mres_rd = '0;
  logic          e_issue, e_ready;
  logic [7:0]    e_a, e_b, e_r;
  logic [3:0]    e_op;

  // Inputs are stable from posedge+1 to the next posedge, so at negedge the
  // model both predicts combinational outputs and steps to the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      for (int i = 0; i < NREG; i++) mreg[i] = 8'h00;
      mres_valid = 1'b0;
      mres_data  = 8'h00;
      mres_rd    = '0;
      check("rst_in_ready", in_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 0);
      check("rst_res_rd", res_rd, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_alu_op", alu_op, 4'hF);
    end else begin
      e_ready = (mq.size() < DEPTH);
      e_issue = (mq.size() > 0) && !ld_valid && (!mres_valid || res_ready);
      e_a  = e_issue ? mreg[mq[0].rs1] : 8'h00;
      e_b  = e_issue ? mreg[mq[0].rs2] : 8'h00;
      e_op = e_issue ? mq[0].op : 4'hF;
      check("in_ready", in_ready, e_ready);
      check("busy", busy, (mq.size() > 0) || mres_valid);
      check("alu_a", alu_a, e_a);
      check("alu_b", alu_b, e_b);
      check("alu_op", alu_op, e_op);
      check("res_valid", res_valid, mres_valid);
      check("res_data", res_data, mres_data);
      check("res_rd", res_rd, mres_rd);
      if (e_issue) begin
        e_r = alu_ref(e_op, e_a, e_b);
        mreg[mq[0].rd] = e_r;
        mres_valid = 1'b1;
        mres_data  = e_r;
        mres_rd    = mq[0].rd;
        mq.delete(0);
      end else if (mres_valid && res_ready) begin
        mres_valid = 1'b0;
      end
      if (ld_valid) mreg[ld_rd] = ld_data;
      if (in_valid && e_ready) begin
        e_ins = '{op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2};
        mq.push_back(e_ins);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [RW-1:0] rd, input logic [7:0] d);
    ld_valid = 1'b1; ld_rd = rd; ld_data = d;
    cyc();
    ld_valid = 1'b0;
  endtask

  task automatic offer(input logic [3:0] op, input logic [RW-1:0] rd,
                       input logic [RW-1:0] rs1, input logic [RW-1:0] rs2);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
  endtask

  logic [3:0] bp_op  [5] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd7};
  logic [7:0] bp_exp [5] = '{8'h08, 8'h02, 8'h01, 8'h06, 8'h07};

  initial begin
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    check("idle_alu_op", alu_op, 4'hF);

    // basic add / sub
    load(0, 8'd5);
    load(1, 8'd3);
    offer(4'd0, 2, 0, 1);
    cyc();
    in_valid = 1'b0;
    cyc();
    check("add_valid", res_valid, 1);
    check("add_data", res_data, 8'h08);
    check("add_rd", res_rd, 2);
    cyc();
    offer(4'd1, 3, 1, 0);
    cyc();
    in_valid = 1'b0;
    cyc();
    check("sub_data", res_data, 8'hFE);
    check("sub_rd", res_rd, 3);
    cyc();

    // back-to-back dependency
    offer(4'd0, 2, 0, 1);
    cyc();
    offer(4'd7, 3, 2, 0);
    cyc();
    in_valid = 1'b0;
    check("dep_first", res_data, 8'h08);
    cyc();
    check("dep_second", res_data, 8'h0D);
    check("dep_second_rd", res_rd, 3);
    cyc();

    // backpressure: one held in result reg, four fill the FIFO
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      offer(bp_op[k], 3, 0, 1);
      cyc();
    end
    offer(4'd0, 2, 0, 1);
    #1;
    check("bp_in_ready", in_ready, 0);
    check("bp_hold_data", res_data, 8'h08);
    cyc();
    check("bp_stable_data", res_data, 8'h08);
    check("bp_still_full", in_ready, 0);
    in_valid  = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_drain_valid", res_valid, 1);
      check("bp_drain_data", res_data, bp_exp[k]);
      cyc();
    end
    check("bp_drained", res_valid, 0);

    // load priority slips issue by one cycle
    load(0, 8'h01);
    offer(4'd2, 2, 1, 0);
    cyc();
    in_valid = 1'b0;
    ld_valid = 1'b1; ld_rd = 1; ld_data = 8'h80;
    #1;
    check("ldp_idle_op", alu_op, 4'hF);
    check("ldp_busy", busy, 1);
    cyc();
    ld_valid = 1'b0;
    #1;
    check("ldp_alu_a", alu_a, 8'h80);
    check("ldp_alu_op", alu_op, 4'd2);
    cyc();
    check("ldp_result", res_data, 8'h00);
    check("ldp_valid", res_valid, 1);
    cyc();

    // illegal opcode writes 0
    load(0, 8'h55);
    offer(4'b1010, 0, 0, 0);
    cyc();
    in_valid = 1'b0;
    cyc();
    check("ill_data", res_data, 8'h00);
    check("ill_rd", res_rd, 0);
    cyc();
    load(1, 8'h02);
    offer(4'd0, 2, 0, 1);
    cyc();
    in_valid = 1'b0;
    cyc();
    check("ill_r0_cleared", res_data, 8'h02);
    cyc();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      in_op     = 4'($urandom_range(0, 15));
      in_rd     = RW'($urandom_range(0, NREG - 1));
      in_rs1    = RW'($urandom_range(0, NREG - 1));
      in_rs2    = RW'($urandom_range(0, NREG - 1));
      ld_valid  = ($urandom_range(0, 9) < 2);
      ld_rd     = RW'($urandom_range(0, NREG - 1));
      ld_data   = 8'($urandom_range(0, 255));
      res_ready = ($urandom_range(0, 9) < 7);
      cyc();
    end
    in_valid = 1'b0; ld_valid = 1'b0; res_ready = 1'b1;
    repeat (8) cyc();

    // asynchronous reset mid-stream
    load(0, 8'h11);
    load(1, 8'h22);
    load(2, 8'h33);
    load(3, 8'h44);
    res_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      offer(4'd0, 0, 1, 2);
      cyc();
    end
    in_valid = 1'b0;
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_op", alu_op, 4'hF);
    cyc();
    rst_n = 1'b1;
    res_ready = 1'b1;
    offer(4'd0, 0, 0, 1);
    cyc();
    offer(4'd0, 1, 2, 3);
    cyc();
    in_valid = 1'b0;
    check("post_rst_r01", res_data, 8'h00);
    cyc();
    check("post_rst_r23", res_data, 8'h00);
    check("post_rst_rd", res_rd, 1);
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
